// File: rtl/freq_div_pkg.sv
// ---------------------------------------------------------------------------
// freq_div_pkg : shared types and helpers for the clock-divider controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package freq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    STOP = 2'd3
  } ctrl_state_t;

  localparam int MIN_DIV = 2;

  function automatic logic div_legal(input int div, input int max);
    return (div >= MIN_DIV) && (div <= max);
  endfunction

endpackage

`default_nettype wire

// File: rtl/freq_div_core.sv
// ---------------------------------------------------------------------------
// freq_div_core : period counter and registered new_clk/tick generation
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module freq_div_core #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             load_div,
  input  logic [WIDTH-1:0] div,
  output logic             boundary,
  output logic             new_clk,
  output logic             tick
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             running;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH:0]   half;

  // One extra bit keeps div+1 from wrapping when div is at the top of its range.
  assign half     = ({1'b0, div} + (WIDTH+1)'(1)) >> 1;
  assign boundary = running && (cnt == div - ONE);

  always_comb begin
    cnt_next = cnt + ONE;
    if (!running || load_div || boundary) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      cnt     <= '0;
      new_clk <= 1'b0;
      tick    <= 1'b0;
    end else if (!run) begin
      running <= 1'b0;
      cnt     <= '0;
      new_clk <= 1'b0;
      tick    <= 1'b0;
    end else begin
      running <= 1'b1;
      cnt     <= cnt_next;
      new_clk <= ({1'b0, cnt_next} < half);
      tick    <= (cnt_next == '0);
    end
  end

endmodule

`default_nettype wire

// File: rtl/freq_div_ctrl.sv
// ---------------------------------------------------------------------------
// freq_div_ctrl : runtime-programmable divider with boundary-aligned changes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module freq_div_ctrl
  import freq_div_pkg::*;
#(
  parameter int MAX_DIV     = 256,
  parameter int DEFAULT_DIV = 7,
  parameter int WIDTH       = $clog2(MAX_DIV + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             new_clk,
  output logic             tick,
  output logic [WIDTH-1:0] active_div,
  output logic             busy
);

  ctrl_state_t      state;
  logic [WIDTH-1:0] pend_div;
  logic             pend_valid;
  logic             xfer;
  logic             legal;
  logic             accept;
  logic             boundary;
  logic             stop_now;
  logic             run;
  logic             load_div;

  assign cfg_ready = !pend_valid;
  assign busy      = (state != IDLE);
  assign xfer      = cfg_valid && cfg_ready;
  assign legal     = div_legal(32'(cfg_div), MAX_DIV);
  assign accept    = xfer && legal;

  // The waveform may only halt on a boundary; a ratio accepted in STOP keeps it alive.
  assign stop_now  = boundary && !en &&
                     ((state == PEND) || ((state == STOP) && !accept));
  assign run       = (state != IDLE) && !stop_now;
  assign load_div  = boundary && (state == PEND);

  freq_div_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .load_div (load_div),
    .div      (active_div),
    .boundary (boundary),
    .new_clk  (new_clk),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      active_div <= WIDTH'(DEFAULT_DIV);
      pend_div   <= '0;
      pend_valid <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= xfer && !legal;
      case (state)
        IDLE: begin
          if (accept) begin
            active_div <= cfg_div;
          end
          if (en) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            pend_div   <= cfg_div;
            pend_valid <= 1'b1;
            state      <= PEND;
          end else if (!en) begin
            state <= STOP;
          end
        end
        STOP: begin
          if (accept) begin
            pend_div   <= cfg_div;
            pend_valid <= 1'b1;
            state      <= PEND;
          end else if (en) begin
            state <= RUN;
          end else if (boundary) begin
            state <= IDLE;
          end
        end
        PEND: begin
          if (boundary) begin
            active_div <= pend_div;
            pend_valid <= 1'b0;
            state      <= en ? RUN : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_freq_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_freq_div_ctrl : directed + random checks of freq_div_ctrl vs a reference
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_freq_div_ctrl;

  localparam int MAX_DIV = 256;
  localparam int DEF_DIV = 7;
  localparam int W       = $clog2(MAX_DIV + 1);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_div = '0;
  logic         cfg_ready;
  logic         cfg_err;
  logic         new_clk;
  logic         tick;
  logic [W-1:0] active_div;
  logic         busy;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference: divider engaged?, waiting to wind down?, waveform position, ratio.
  bit m_busy, m_wind, m_started, m_err;
  int m_pos, m_ratio;
  int pend_q[$];

  freq_div_ctrl #(
    .MAX_DIV     (MAX_DIV),
    .DEFAULT_DIV (DEF_DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .new_clk    (new_clk),
    .tick       (tick),
    .active_div (active_div),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_busy = 0; m_wind = 0; m_started = 0; m_err = 0;
    m_pos = 0; m_ratio = DEF_DIV;
    pend_q.delete();
  endfunction

  function automatic void model_edge(input bit e, input bit v, input int d);
    bit bnd   = m_started && (m_pos == m_ratio - 1);
    bit ready = (pend_q.size() == 0);
    bit xfer  = v && ready;
    bit ok    = xfer && (d >= 2) && (d <= MAX_DIV);
    bit halt  = 0;
    bit was_busy = m_busy;
    m_err = xfer && !ok;
    if (!m_busy) begin
      if (ok) m_ratio = d;
      m_busy = e;
      m_wind = 0;
    end else if (!ready) begin
      if (bnd) begin
        m_ratio = pend_q.pop_front();
        halt    = !e;
        m_busy  = e;
      end
      m_wind = 0;
    end else if (ok) begin
      pend_q.push_back(d);
      m_wind = 0;
    end else if (m_wind && bnd && !e) begin
      halt   = 1;
      m_busy = 0;
      m_wind = 0;
    end else begin
      m_wind = !e;
    end
    if (!was_busy || halt) begin
      m_started = 0;
      m_pos     = 0;
    end else if (!m_started) begin
      m_started = 1;
      m_pos     = 0;
    end else begin
      m_pos = bnd ? 0 : m_pos + 1;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit exp_clk  = m_started && (m_pos < (m_ratio + 1) / 2);
    bit exp_tick = m_started && (m_pos == 0);
    check("new_clk",    {31'b0, new_clk},   {31'b0, exp_clk});
    check("tick",       {31'b0, tick},      {31'b0, exp_tick});
    check("cfg_ready",  {31'b0, cfg_ready}, {31'b0, (pend_q.size() == 0)});
    check("cfg_err",    {31'b0, cfg_err},   {31'b0, m_err});
    check("busy",       {31'b0, busy},      {31'b0, m_busy});
    check("active_div", 32'(active_div),    m_ratio);
  endtask

  task automatic cycle(input bit e, input bit v, input int d);
    en        = e;
    cfg_valid = v;
    cfg_div   = d[W-1:0];
    @(posedge clk);
    model_edge(e, v, d);
    #1;
    check_all();
  endtask

  task automatic run_n(input int n, input bit e);
    for (int i = 0; i < n; i++) cycle(e, 1'b0, 0);
  endtask

  task automatic run_until(input int k, input int ratio, input bit e);
    bit hit = 0;
    for (int i = 0; i < 600 && !hit; i++) begin
      if (m_started && m_pos == k && m_ratio == ratio) hit = 1;
      else cycle(e, 1'b0, 0);
    end
    check("wait_pos", {31'b0, hit}, 32'd1);
  endtask

  task automatic wait_idle();
    bit hit = 0;
    for (int i = 0; i < 600 && !hit; i++) begin
      if (!m_busy) hit = 1;
      else cycle(1'b0, 1'b0, 0);
    end
    check("wait_idle", {31'b0, hit}, 32'd1);
  endtask

  initial begin
    bit e;
    int r, d;
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // Default ratio 7 straight out of reset
    run_n(20, 1'b1);

    // Stop, load 4 while idle, restart
    wait_idle();
    cycle(1'b0, 1'b1, 4);
    run_n(12, 1'b1);

    // Ratio 7 -> 10 offered at cnt=2
    cycle(1'b1, 1'b1, 7);
    run_until(2, 7, 1'b1);
    cycle(1'b1, 1'b1, 10);
    run_n(25, 1'b1);

    // Illegal ratios, then the extremes 2 and MAX_DIV
    cycle(1'b1, 1'b1, 1);
    run_n(3, 1'b1);
    cycle(1'b1, 1'b1, MAX_DIV + 1);
    run_n(3, 1'b1);
    cycle(1'b1, 1'b1, 0);
    run_n(2, 1'b1);
    cycle(1'b1, 1'b1, 2);
    run_n(16, 1'b1);
    cycle(1'b1, 1'b1, MAX_DIV);
    run_n(MAX_DIV + 6, 1'b1);

    // Stop at cnt=1 with ratio 6, then drop/raise en before the boundary
    cycle(1'b1, 1'b1, 6);
    run_until(1, 6, 1'b1);
    wait_idle();
    run_n(3, 1'b0);
    run_until(3, 6, 1'b1);
    run_n(2, 1'b0);
    run_n(15, 1'b1);

    // Asynchronous reset mid high phase with a ratio pending
    run_until(0, 6, 1'b1);
    cycle(1'b1, 1'b1, 9);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    run_n(20, 1'b1);

    // Random traffic
    e = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 11) == 0) e = !e;
      r = $urandom_range(0, 15);
      d = (r < 12) ? r : (r == 12) ? MAX_DIV : (r == 13) ? MAX_DIV + 1 : (r == 14) ? 0 : 3;
      cycle(e, ($urandom_range(0, 3) == 0), d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/freq_div_ctrl.md
Name: freq_div_ctrl

Overview:
Runtime-programmable clock-divider controller. It generates new_clk from clk at a divide ratio loaded through a valid/ready configuration port. Ratio changes and stop requests take effect only at a period boundary, so new_clk never produces a runt pulse. It sits between the configuration logic and any logic clocked or enabled by the divided clock.

Parameters:
MAX_DIV, 256, largest legal divide ratio.
DEFAULT_DIV, 7, ratio loaded at reset; must satisfy 2 <= DEFAULT_DIV <= MAX_DIV.
WIDTH, $clog2(MAX_DIV+1), derived width of the ratio and counter; not overridden by users.

Ports:
clk  input  1  system clock.
rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
en  input  1  level; 1 = run divider, 0 = stop at the next period boundary.
cfg_valid  input  1  new ratio offered on cfg_div.
cfg_div  input  WIDTH  requested divide ratio.
cfg_ready  output  1  controller can accept a ratio.
cfg_err  output  1  one-cycle pulse: offered ratio was rejected.
new_clk  output  1  divided clock, registered.
tick  output  1  one-cycle pulse on each cycle where new_clk rises.
active_div  output  WIDTH  ratio currently in use.
busy  output  1  state != IDLE.

Behaviour:
- Reset values (asynchronous):
  - new_clk=0, tick=0, cfg_err=0, cfg_ready=1, busy=0.
  - active_div=DEFAULT_DIV, cnt=0, pend_valid=0, state=IDLE.
- States: IDLE, RUN, PEND, STOP.
- Waveform in RUN, PEND and STOP:
  - cnt counts 0..active_div-1, then wraps to 0.
  - new_clk=1 while cnt < H, where H = ceil(active_div/2); otherwise 0.
  - tick=1 when cnt==0.
  - Period = active_div clk cycles; high phase = H cycles.
  - new_clk and tick are registered alongside cnt. The first clk edge after leaving IDLE gives cnt=0, new_clk=1, tick=1.
- Boundary: the cycle where cnt==active_div-1.
- IDLE:
  - cnt held at 0; new_clk=0.
  - en=1 -> RUN.
- Configuration handshake:
  - A transfer occurs on a clk edge with cfg_valid & cfg_ready.
  - Legal ratio: 2 <= cfg_div <= MAX_DIV.
  - Illegal ratio: the transfer is consumed, cfg_err pulses for 1 cycle on the next cycle, and nothing else changes.
  - Legal ratio accepted in IDLE: active_div updates on the next cycle; cfg_ready stays 1.
  - Legal ratio accepted in RUN: stored in a pending register, pend_valid=1, state -> PEND, cfg_ready=0.
  - cfg_ready = !pend_valid.
- PEND:
  - At the boundary, active_div <= pending value and cnt <= 0, so the new period starts with the new ratio.
  - pend_valid clears and cfg_ready returns to 1 on that edge.
  - The next state is RUN if en=1, else IDLE.
- en deasserted while in RUN: state -> STOP; the waveform continues unchanged.
- STOP:
  - At the boundary -> IDLE, with new_clk=0 and cnt=0.
  - en reasserted before the boundary -> RUN with no waveform disturbance.
- en deasserted while in PEND:
  - Stay in PEND; at the boundary apply the pending ratio, then -> IDLE.
  - This case needs no separate stop flag; the PEND exit rule covers it.
- Simultaneous events:
  - A transfer on the same edge as the boundary while in RUN is stored as pending. It applies at the following boundary, not the current one.
  - cfg_valid while cfg_ready=0 is ignored; the requester must hold cfg_valid.
- Ratio change has at most (active_div) cycles of latency from acceptance.
- The high phase never shortens on a change because changes only occur at boundaries.
- Reset mid-operation: all outputs return to reset values immediately and asynchronously; the pending ratio is discarded.
- Arithmetic:
  - cnt is WIDTH bits.
  - H is computed as (active_div+1)>>1 in WIDTH+1 bits so MAX_DIV at a power-of-two boundary does not overflow.

Decomposition:
- Shared package freq_div_pkg holds:
  - state enum ctrl_state_t {IDLE, RUN, PEND, STOP};
  - constant MIN_DIV=2;
  - a function div_legal(div, max) returning the legality check.
- One sub-module is natural: freq_div_core.
  - Holds the cnt and new_clk/tick registers.
  - Inputs: run, load_div, div.
  - Outputs: boundary, new_clk, tick.
- The FSM and handshake stay in freq_div_ctrl.

Test Plan:
1. Reset, en=1, no config -> new_clk period 7 cycles, high 4/low 3; tick every 7 cycles; active_div=7; busy=1.
2. IDLE, cfg_div=4 accepted, then en=1 -> period 4, high 2/low 2; cfg_ready never drops.
3. RUN at div 7, cfg_div=10 accepted at cnt=2 -> cfg_ready=0; the current 7-cycle period completes intact. The next period is 10 cycles (high 5); cfg_ready=1 from that boundary.
4. Offer cfg_div=1, then cfg_div=MAX_DIV+1 (257) -> cfg_err pulses each time; active_div unchanged; waveform undisturbed.
5. en dropped at cnt=1 (div 6) -> the period finishes, then new_clk=0 and busy=0 at the boundary. A second run drops en and re-raises it before the boundary -> no gap in the waveform.
6. Assert rst_n=0 mid high phase with a pending ratio -> new_clk=0 immediately and active_div=DEFAULT_DIV. After release with en=1, the period is 7 and the pending ratio is lost.
